// File: rtl/seq_bit_serializer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : seq_bit_serializer
//  Purpose  : Parallel-in, serial-out stimulus stage with valid/ready load,
//             stall, and last-bit marker for feeding serial sequence detectors.
//  Revision : 1.0  initial release
// ============================================================================
module seq_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             stall,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_last,
  output logic             busy
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ser_out;
  logic               r_ser_valid;
  logic               r_frame_last;
  logic               r_busy;

  state_t             w_state_nxt;
  logic [WIDTH-1:0]   w_shift_nxt;
  logic [c_cnt_w-1:0] w_cnt_nxt;
  logic [c_cnt_w-1:0] w_cnt_inc;
  logic               w_ser_out_nxt;
  logic               w_ser_valid_nxt;
  logic               w_frame_last_nxt;
  logic               w_busy_nxt;
  logic               w_last;
  logic               w_accept;

  // r_shift holds only the bits not yet presented, next one at the head.
  logic               w_first_bit;
  logic [WIDTH-1:0]   w_shift_load;
  logic               w_next_bit;
  logic [WIDTH-1:0]   w_shift_adv;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_first_bit  = load_data[WIDTH-1];
      assign w_shift_load = {load_data[WIDTH-2:0], 1'b0};
      assign w_next_bit   = r_shift[WIDTH-1];
      assign w_shift_adv  = {r_shift[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign w_first_bit  = load_data[0];
      assign w_shift_load = {1'b0, load_data[WIDTH-1:1]};
      assign w_next_bit   = r_shift[0];
      assign w_shift_adv  = {1'b0, r_shift[WIDTH-1:1]};
    end
  endgenerate

  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_last     = (r_cnt == c_last_cnt);
    load_ready = (r_state == ST_IDLE) ||
                 ((r_state == ST_SHIFT) && w_last && !stall);
    w_accept   = load_valid && load_ready;

    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_ser_out_nxt    = r_ser_out;
    w_ser_valid_nxt  = r_ser_valid;
    w_frame_last_nxt = r_frame_last;
    w_busy_nxt       = r_busy;

    if (w_accept) begin
      w_state_nxt      = ST_SHIFT;
      w_shift_nxt      = w_shift_load;
      w_cnt_nxt        = '0;
      w_ser_out_nxt    = w_first_bit;
      w_ser_valid_nxt  = 1'b1;
      w_frame_last_nxt = 1'b0;
      w_busy_nxt       = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_ser_out_nxt    = IDLE_LEVEL;
          w_ser_valid_nxt  = 1'b0;
          w_frame_last_nxt = 1'b0;
          w_busy_nxt       = 1'b0;
        end
        ST_SHIFT: begin
          if (stall) begin
            w_ser_valid_nxt = 1'b0;
          end else if (w_last) begin
            // Final bit already went out valid once, so a stall released
            // here ends the word instead of repeating it.
            w_state_nxt      = ST_IDLE;
            w_ser_out_nxt    = IDLE_LEVEL;
            w_ser_valid_nxt  = 1'b0;
            w_frame_last_nxt = 1'b0;
            w_busy_nxt       = 1'b0;
          end else if (!r_ser_valid) begin
            w_ser_valid_nxt = 1'b1;
          end else begin
            w_shift_nxt      = w_shift_adv;
            w_cnt_nxt        = w_cnt_inc;
            w_ser_out_nxt    = w_next_bit;
            w_ser_valid_nxt  = 1'b1;
            w_frame_last_nxt = (w_cnt_inc == c_last_cnt);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_ser_out    <= IDLE_LEVEL;
      r_ser_valid  <= 1'b0;
      r_frame_last <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_ser_out    <= w_ser_out_nxt;
      r_ser_valid  <= w_ser_valid_nxt;
      r_frame_last <= w_frame_last_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  assign ser_out    = r_ser_out;
  assign ser_valid  = r_ser_valid;
  assign frame_last = r_frame_last;
  assign busy       = r_busy;

endmodule
`default_nettype wire
